wwd_display: RTL and testbench
==============================

WWD_DISPLAY -- requirements
Module: wwd_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd50000, the number of clk cycles each display digit is held; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on the posedge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port wwd_valid, input, 1, a one-cycle pulse from the CPU when a WWD instruction writes output_port.
REQ-005 SHALL have port wwd_data, input, 16, the CPU output_port value, sampled when wwd_valid=1.
REQ-006 SHALL have port PC_below8bit, input, 8, the lower byte of the CPU PC.
REQ-007 SHALL have port advance, input, 1, a one-cycle pulse, already debounced, that requests a pop of the FIFO head.
REQ-008 SHALL have port mode, input, 1: 0 = show the FIFO head, 1 = show the PC.
REQ-009 SHALL have port seg, output, 7, active-low segments; seg[0]=a ... seg[6]=g.
REQ-010 SHALL have port an, output, 4, active-low digit enables; an[0] is the rightmost digit.
REQ-011 SHALL have port led, output, 8, a registered copy of PC_below8bit.
REQ-012 SHALL have port fifo_count, output, 3, current FIFO occupancy, 0..4.
REQ-013 SHALL have port overflow, output, 1, sticky flag set when a WWD word is dropped.

Function
REQ-014 SHALL implement a 4-entry, 16-bit FIFO with wrapping 2-bit read/write pointers.
REQ-015 SHALL push wwd_data when wwd_valid=1 and count<4.
REQ-016 SHALL pop when advance=1 and count>0.
REQ-017 SHALL decide push/pop eligibility from the count at the start of the cycle.
REQ-018 SHALL handle simultaneous push and pop as follows:
- count 0: push only.
- count 1..3: both occur; count unchanged.
- count 4: both occur; count stays 4; no overflow.
REQ-019 SHALL drop the word and set overflow=1 when wwd_valid=1, count=4 and advance=0; overflow stays 1 until reset.
REQ-020 SHALL ignore advance when count=0.
REQ-021 SHALL update fifo_count and the displayed value on the clk edge after the push or pop (1-cycle latency).
REQ-022 SHALL run a prescaler counting 0..SCAN_DIV-1; on terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-023 SHALL drive, for digit index i, an = 4'b1111 with bit i cleared, and seg = the encoding of the selected nibble, both registered.
REQ-024 SHALL select digit content as follows:
- mode=0, count>0: digit i shows head[4i+3:4i].
- mode=0, count=0: all digits show dash (7'b0111111).
- mode=1: digits 0,1 show PC_below8bit nibbles; digits 2,3 are blank (7'b1111111).
REQ-025 SHALL use hex encodings 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (written g..a).
REQ-026 SHALL let mode changes take effect at the next clk edge without disturbing the scan position.
REQ-027 SHALL register led from PC_below8bit each cycle (1-cycle latency).

Reset
REQ-028 SHALL, while reset=1:
- empty the FIFO, zero both pointers, fifo_count=0, overflow=0;
- set prescaler=0, digit index=0;
- drive an=4'b1111, seg=7'b1111111, led=8'h00.
REQ-029 SHALL apply reset immediately and asynchronously, including mid-scan and mid-push; no word pushed in the reset cycle is retained.
REQ-030 SHALL drive an=4'b1110 with digit-0 content at the first clk edge after reset deasserts.

Verification (SCAN_DIV=4)
REQ-031 SHALL check: reset, then wwd_valid with 16'h1234, mode=0 -> fifo_count=1 next cycle; digits 0..3 show 4,3,2,1; each an value is held 4 cycles.
REQ-032 SHALL check: push 0x0001, 0x0002, 0x0003, 0x0004, then push 0x0005 -> fifo_count=4, overflow=1; after four advance pulses, values shown in order 1,2,3,4, then dashes at count=0.
REQ-033 SHALL check: count=4, wwd_valid and advance in the same cycle -> count stays 4, overflow stays 0, new head = old second entry.
REQ-034 SHALL check: count=0, wwd_valid=1 (0xBEEF) and advance in the same cycle -> count=1, head=0xBEEF.
REQ-035 SHALL check: mode=1, PC_below8bit=8'h1B -> digit 0 = 0000011 (b), digit 1 = 1111001 (1), digits 2 and 3 blank, led=8'h1B.
REQ-036 SHALL check: reset asserted mid-scan with count=3 -> an=1111, seg=1111111, count=0 and overflow=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/wwd_display.sv
// WWD output display: 4-entry FIFO of CPU output words, multiplexed onto a
// 4-digit active-low 7-segment display, with a PC view selectable by mode.
module wwd_display #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wwd_valid,
  input  logic [15:0] wwd_data,
  input  logic [7:0]  PC_below8bit,
  input  logic        advance,
  input  logic        mode,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [7:0]  led,
  output logic [2:0]  fifo_count,
  output logic        overflow
);

  logic [15:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [15:0] prescaler;
  logic [1:0]  digit;

  logic        full;
  logic        empty;
  logic        do_push;
  logic        do_pop;
  logic [15:0] head;
  logic [3:0]  nibble;
  logic [6:0]  seg_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);
  // A full FIFO still accepts a word when the head is popped in the same cycle.
  assign do_push = wwd_valid && (!full || advance);
  assign do_pop  = advance && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    nibble   = 4'h0;
    seg_next = 7'b1111111;
    if (mode) begin
      nibble = digit[0] ? PC_below8bit[7:4] : PC_below8bit[3:0];
      if (!digit[1]) seg_next = hex_to_seg(nibble);
    end else if (empty) begin
      seg_next = 7'b0111111;
    end else begin
      case (digit)
        2'd0:    nibble = head[3:0];
        2'd1:    nibble = head[7:4];
        2'd2:    nibble = head[11:8];
        default: nibble = head[15:12];
      endcase
      seg_next = hex_to_seg(nibble);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= 16'h0000;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wwd_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      if (do_push && !do_pop)      count <= count + 3'd1;
      else if (do_pop && !do_push) count <= count - 3'd1;
      if (wwd_valid && full && !advance) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= 16'd0;
      digit     <= 2'd0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      led       <= 8'h00;
    end else begin
      if (prescaler == SCAN_DIV - 16'd1) begin
        prescaler <= 16'd0;
        digit     <= digit + 2'd1;
      end else begin
        prescaler <= prescaler + 16'd1;
      end
      an  <= ~(4'b0001 << digit);
      seg <= seg_next;
      led <= PC_below8bit;
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_wwd_display.sv
// Self-checking bench for wwd_display: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wwd_display;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wwd_valid = 1'b0;
  logic [15:0] wwd_data = 16'h0000;
  logic [7:0]  PC_below8bit = 8'h00;
  logic        advance = 1'b0;
  logic        mode = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [7:0]  led;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  wwd_display #(.SCAN_DIV(16'(SD))) dut (
    .clk(clk), .reset(reset), .wwd_valid(wwd_valid), .wwd_data(wwd_data),
    .PC_below8bit(PC_below8bit), .advance(advance), .mode(mode),
    .seg(seg), .an(an), .led(led), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [6:0] enc [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, scan position from edges since reset.
  logic [15:0] q [$];
  logic        m_ovf = 1'b0;
  int          n_edges = 0;
  logic [3:0]  exp_an = 4'b1111;
  logic [6:0]  exp_seg = 7'b1111111;
  logic [7:0]  exp_led = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf   = 1'b0;
      n_edges = 0;
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
      exp_led = 8'h00;
    end else begin
      int d;
      int c;
      logic [15:0] h;
      d = (n_edges / SD) % 4;
      exp_an = 4'b1111;
      exp_an[d] = 1'b0;
      if (mode) exp_seg = (d < 2) ? enc[(PC_below8bit >> (4 * d)) & 8'hF] : 7'b1111111;
      else if (q.size() == 0) exp_seg = 7'b0111111;
      else begin
        h = q[0];
        exp_seg = enc[(h >> (4 * d)) & 16'hF];
      end
      exp_led = PC_below8bit;
      c = q.size();
      if (wwd_valid && c == 4 && !advance) m_ovf = 1'b1;
      if (advance && c > 0) void'(q.pop_front());
      if (wwd_valid && (c < 4 || advance)) q.push_back(wwd_data);
      n_edges++;
    end
  end

  always @(negedge clk) begin
    check("model_an", {12'h0, an}, {12'h0, exp_an});
    check("model_seg", {9'h0, seg}, {9'h0, exp_seg});
    check("model_led", {8'h0, led}, {8'h0, exp_led});
    check("model_count", {13'h0, fifo_count}, 16'(q.size()));
    check("model_ovf", {15'h0, overflow}, {15'h0, m_ovf});
  end

  task automatic step(input logic v, input logic [15:0] d, input logic a);
    @(negedge clk);
    wwd_valid = v;
    wwd_data  = d;
    advance   = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    wwd_valid = 1'b0;
    advance   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // Waits (bounded) until digit d is enabled; the final compare flags a timeout.
  task automatic wait_digit(input int d);
    logic [3:0] target;
    target = 4'b1111;
    target[d] = 1'b0;
    for (int i = 0; i < 4 * SD + 4; i++) begin
      @(negedge clk);
      if (an == target) break;
    end
    check("digit_reach", {12'h0, an}, {12'h0, target});
  endtask

  initial begin
    int hold;
    PC_below8bit = 8'h00;
    do_reset();
    #1 check("reset_an", {12'h0, an}, 16'h000F);
    check("reset_count", {13'h0, fifo_count}, 16'h0000);

    // Single word 0x1234, scan order and dwell time.
    step(1'b1, 16'h1234, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check("push1_count", {13'h0, fifo_count}, 16'h0001);
    wait_digit(0);
    check("d0_is_4", {9'h0, seg}, {9'h0, 7'b0011001});
    wait_digit(1);
    check("d1_is_3", {9'h0, seg}, {9'h0, 7'b0110000});
    hold = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (an != 4'b1101) break;
      hold++;
    end
    check("dwell", 16'(hold), 16'(SD));
    wait_digit(2);
    check("d2_is_2", {9'h0, seg}, {9'h0, 7'b0100100});
    wait_digit(3);
    check("d3_is_1", {9'h0, seg}, {9'h0, 7'b1111001});

    // Fill, overflow on fifth word, then drain in order.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check("full_count", {13'h0, fifo_count}, 16'h0004);
    check("ovf_set", {15'h0, overflow}, 16'h0001);
    wait_digit(0);
    check("head_1", {9'h0, seg}, {9'h0, 7'b1111001});
    step(1'b0, 16'h0000, 1'b1); idle(1);
    wait_digit(0);
    check("head_2", {9'h0, seg}, {9'h0, 7'b0100100});
    step(1'b0, 16'h0000, 1'b1); idle(1);
    wait_digit(0);
    check("head_3", {9'h0, seg}, {9'h0, 7'b0110000});
    step(1'b0, 16'h0000, 1'b1); idle(1);
    wait_digit(0);
    check("head_4", {9'h0, seg}, {9'h0, 7'b0011001});
    step(1'b0, 16'h0000, 1'b1); idle(1);
    wait_digit(2);
    check("empty_dash", {9'h0, seg}, {9'h0, 7'b0111111});
    check("drain_count", {13'h0, fifo_count}, 16'h0000);
    check("ovf_sticky", {15'h0, overflow}, 16'h0001);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    step(1'b1, 16'h1111, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    step(1'b1, 16'h3333, 1'b0);
    step(1'b1, 16'h4444, 1'b0);
    step(1'b1, 16'h5555, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    check("both_full_count", {13'h0, fifo_count}, 16'h0004);
    check("both_full_ovf", {15'h0, overflow}, 16'h0000);
    idle(1);
    wait_digit(0);
    check("both_full_head", {9'h0, seg}, {9'h0, 7'b0100100});

    // Empty FIFO with simultaneous push and pop.
    do_reset();
    step(1'b1, 16'hBEEF, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    check("both_empty_count", {13'h0, fifo_count}, 16'h0001);
    wait_digit(0);
    check("beef_d0", {9'h0, seg}, {9'h0, 7'b0001110});
    wait_digit(3);
    check("beef_d3", {9'h0, seg}, {9'h0, 7'b0000011});

    // PC view.
    @(negedge clk);
    mode = 1'b1;
    PC_below8bit = 8'h1B;
    idle(2);
    check("led_pc", {8'h0, led}, 16'h001B);
    wait_digit(0);
    check("pc_d0", {9'h0, seg}, {9'h0, 7'b0000011});
    wait_digit(1);
    check("pc_d1", {9'h0, seg}, {9'h0, 7'b1111001});
    wait_digit(2);
    check("pc_d2", {9'h0, seg}, {9'h0, 7'b1111111});
    wait_digit(3);
    check("pc_d3", {9'h0, seg}, {9'h0, 7'b1111111});
    @(negedge clk);
    mode = 1'b0;

    // Asynchronous reset mid-scan with three words held.
    do_reset();
    step(1'b1, 16'hA001, 1'b0);
    step(1'b1, 16'hA002, 1'b0);
    step(1'b1, 16'hA003, 1'b0);
    idle(6);
    check("pre_rst_count", {13'h0, fifo_count}, 16'h0003);
    #2 reset = 1'b1;
    #1;
    check("async_an", {12'h0, an}, 16'h000F);
    check("async_seg", {9'h0, seg}, 16'h007F);
    check("async_count", {13'h0, fifo_count}, 16'h0000);
    check("async_ovf", {15'h0, overflow}, 16'h0000);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("post_rst_an", {12'h0, an}, 16'h000E);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wwd_valid = ($urandom_range(0, 99) < 40);
      wwd_data  = 16'($urandom);
      advance   = ($urandom_range(0, 99) < 30);
      PC_below8bit = 8'($urandom);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if (i == 1500) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
